// File: rtl/alu_seq.sv
// Multi-cycle ALU: single-cycle logic ops, serial shifter (1 bit/cycle), optional serial multiplier.
// Define ALU_SEQ_MUL_EN to enable alu_op 1100 (MUL, shift-add, WIDTH+1 cycle latency).
module alu_seq #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] rfrd1,
    input  logic [WIDTH-1:0] rfrd2,
    input  logic [WIDTH-1:0] sextext,
    input  logic             alub_sel,
    input  logic [3:0]       alu_op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] C,
    output logic             zero,
    output logic             sgn
);
    localparam int SHW = $clog2(WIDTH);
    localparam int CW  = SHW + 1;

    localparam logic [3:0] OP_AND  = 4'b0000;
    localparam logic [3:0] OP_OR   = 4'b0001;
    localparam logic [3:0] OP_ADD  = 4'b0010;
    localparam logic [3:0] OP_SLTU = 4'b0011;
    localparam logic [3:0] OP_XOR  = 4'b0101;
    localparam logic [3:0] OP_SUB  = 4'b0110;
    localparam logic [3:0] OP_SLT  = 4'b0111;
    localparam logic [3:0] OP_SLL  = 4'b1000;
    localparam logic [3:0] OP_SRL  = 4'b1010;
    localparam logic [3:0] OP_SRA  = 4'b1011;

    // state | meaning: IDLE accept | SHIFT one bit per cycle | MUL one multiplier bit per cycle | DONE hold result
`ifdef ALU_SEQ_MUL_EN
    localparam logic [3:0] OP_MUL = 4'b1100;
    typedef enum logic [1:0] {IDLE, SHIFT, MUL, DONE} state_t;
`else
    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
`endif

    state_t            state_q, state_d;
    logic [WIDTH-1:0]  a_q, a_d;
    logic [3:0]        op_q, op_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [WIDTH-1:0]  c_q, c_d;
    logic [WIDTH-1:0]  bmux;
    logic [WIDTH-1:0]  alu_res;
    logic [WIDTH-1:0]  shifted;
    logic              is_shift;
`ifdef ALU_SEQ_MUL_EN
    logic [WIDTH-1:0]  b_q, b_d;
    logic [WIDTH-1:0]  p_q, p_d;
    logic [WIDTH-1:0]  mul_sum;

    assign mul_sum = p_q + (b_q[0] ? a_q : '0);
`endif

    assign bmux     = alub_sel ? sextext : rfrd2;
    assign is_shift = (alu_op == OP_SLL) || (alu_op == OP_SRL) || (alu_op == OP_SRA);

    always_comb begin
        alu_res = '0;
        case (alu_op)
            OP_AND:  alu_res = rfrd1 & bmux;
            OP_OR:   alu_res = rfrd1 | bmux;
            OP_ADD:  alu_res = rfrd1 + bmux;
            OP_SUB:  alu_res = rfrd1 + ~bmux + 1'b1;
            OP_XOR:  alu_res = rfrd1 ^ bmux;
            OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, ($signed(rfrd1) < $signed(bmux))};
            OP_SLTU: alu_res = {{(WIDTH-1){1'b0}}, (rfrd1 < bmux)};
            default: alu_res = '0;
        endcase
    end

    always_comb begin
        shifted = {a_q[WIDTH-1], a_q[WIDTH-1:1]};
        case (op_q)
            OP_SLL:  shifted = {a_q[WIDTH-2:0], 1'b0};
            OP_SRL:  shifted = {1'b0, a_q[WIDTH-1:1]};
            default: shifted = {a_q[WIDTH-1], a_q[WIDTH-1:1]};
        endcase
    end

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        op_d    = op_q;
        cnt_d   = cnt_q;
        c_d     = c_q;
`ifdef ALU_SEQ_MUL_EN
        b_d     = b_q;
        p_d     = p_q;
`endif
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_d  = rfrd1;
                    op_d = alu_op;
                    if (is_shift) begin
                        cnt_d = {1'b0, bmux[SHW-1:0]};
                        if (bmux[SHW-1:0] == '0) begin
                            c_d     = rfrd1;
                            state_d = DONE;
                        end else begin
                            state_d = SHIFT;
                        end
                    end
`ifdef ALU_SEQ_MUL_EN
                    else if (alu_op == OP_MUL) begin
                        b_d     = bmux;
                        p_d     = '0;
                        cnt_d   = CW'(WIDTH);
                        state_d = MUL;
                    end
`endif
                    else begin
                        c_d     = alu_res;
                        state_d = DONE;
                    end
                end
            end
            SHIFT: begin
                a_d   = shifted;
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    c_d     = shifted;
                    state_d = DONE;
                end
            end
`ifdef ALU_SEQ_MUL_EN
            MUL: begin
                p_d   = mul_sum;
                a_d   = {a_q[WIDTH-2:0], 1'b0};
                b_d   = {1'b0, b_q[WIDTH-1:1]};
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    c_d     = mul_sum;
                    state_d = DONE;
                end
            end
`endif
            DONE: begin
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            op_q    <= '0;
            cnt_q   <= '0;
            c_q     <= '0;
`ifdef ALU_SEQ_MUL_EN
            b_q     <= '0;
            p_q     <= '0;
`endif
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            op_q    <= op_d;
            cnt_q   <= cnt_d;
            c_q     <= c_d;
`ifdef ALU_SEQ_MUL_EN
            b_q     <= b_d;
            p_q     <= p_d;
`endif
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign C         = c_q;
    assign zero      = (c_q == '0);
    assign sgn       = c_q[WIDTH-1];
endmodule

// File: tb/tb_alu_seq.sv
// Scoreboard bench for alu_seq: driver queues model results, monitor checks each presented result.
module tb_alu_seq;
    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst, in_valid, in_ready, alub_sel, out_valid, out_ready, zero, sgn;
    logic [W-1:0] rfrd1, rfrd2, sextext, C;
    logic [3:0]   alu_op;
    logic         or_force, or_val, or_rand;

    alu_seq #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .rfrd1(rfrd1), .rfrd2(rfrd2), .sextext(sextext), .alub_sel(alub_sel),
        .alu_op(alu_op), .out_valid(out_valid), .out_ready(out_ready),
        .C(C), .zero(zero), .sgn(sgn)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    assign out_ready = or_force ? or_val : or_rand;
    always @(negedge clk) or_rand = ($urandom_range(0, 3) != 0);

    typedef struct {
        logic [W-1:0] c;
        int           lat;
        int           cyc0;
    } exp_t;

    exp_t sb[$];
    int   n_vec = 0;
    int   n_err = 0;

    task automatic check(input string nm, input logic [W-1:0] act, input logic [W-1:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s actual=%h required=%h", nm, act, req);
        end
    endtask

    // Reference: plain arithmetic on operands, latency from the documented timing rules.
    function automatic logic [W-1:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                           input logic [3:0] op, output int lat);
        int unsigned sh;
        logic [W-1:0] r;
        sh  = b % W;
        lat = 1;
        case (op)
            4'b0000: r = a & b;
            4'b0001: r = a | b;
            4'b0010: r = a + b;
            4'b0110: r = a - b;
            4'b0101: r = a ^ b;
            4'b1000: begin r = a << sh; lat = sh + 1; end
            4'b1010: begin r = a >> sh; lat = sh + 1; end
            4'b1011: begin r = $signed(a) >>> sh; lat = sh + 1; end
            4'b0111: r = ($signed(a) < $signed(b)) ? 1 : 0;
            4'b0011: r = (a < b) ? 1 : 0;
`ifdef ALU_SEQ_MUL_EN
            4'b1100: begin r = a * b; lat = W + 1; end
`endif
            default: r = 0;
        endcase
        return r;
    endfunction

    task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic [W-1:0] s,
                         input logic sel, input logic [3:0] op, input bit track);
        int   t;
        exp_t e;
        t = 0;
        while (!in_ready && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (!in_ready) begin
            n_vec++;
            n_err++;
            $display("FAIL issue_wait in_ready=%0b required 1", in_ready);
            return;
        end
        e.c    = model(a, sel ? s : b, op, e.lat);
        e.cyc0 = cyc;
        if (track) sb.push_back(e);
        rfrd1 = a; rfrd2 = b; sextext = s; alub_sel = sel; alu_op = op;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        rfrd1 = $urandom; rfrd2 = $urandom; sextext = $urandom;
        alub_sel = 1'($urandom); alu_op = 4'($urandom);
    endtask

    task automatic drain();
        int t;
        t = 0;
        while ((sb.size() != 0 || !in_ready) && t < 300) begin
            @(negedge clk);
            t++;
        end
        n_vec++;
        if (sb.size() != 0 || !in_ready) begin
            n_err++;
            $display("FAIL drain pending=%0d in_ready=%0b required 0 and 1", sb.size(), in_ready);
        end
    endtask

    exp_t cur;
    bit   have    = 0;
    bit   prev_ov = 0;
    always @(negedge clk) begin
        if (rst) begin
            prev_ov = 0;
            have    = 0;
        end else begin
            if (out_valid && !prev_ov) begin
                if (sb.size() == 0) begin
                    n_vec++;
                    n_err++;
                    have = 0;
                    $display("FAIL unexpected_result C=%h required no result", C);
                end else begin
                    cur  = sb.pop_front();
                    have = 1;
                    check("C", C, cur.c);
                    check("latency", W'(cyc - cur.cyc0), W'(cur.lat));
                    check("zero", W'(zero), W'(cur.c == 0));
                    check("sgn", W'(sgn), W'(cur.c[W-1]));
                end
            end else if (out_valid && have) begin
                check("C_hold", C, cur.c);
            end
            prev_ov = out_valid;
        end
    end

    logic [3:0] ops [12] = '{4'b0000, 4'b0001, 4'b0010, 4'b0110, 4'b0101, 4'b1000,
                             4'b1010, 4'b1011, 4'b0111, 4'b0011, 4'b1100, 4'b1111};

    initial begin
        logic [3:0]   op;
        logic [W-1:0] a, b, s, hold_c;
        int           hl;
        rst = 1'b1; in_valid = 1'b0; rfrd1 = '0; rfrd2 = '0; sextext = '0;
        alub_sel = 1'b0; alu_op = '0; or_force = 1'b1; or_val = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_out_valid", W'(out_valid), W'(0));
        check("rst_in_ready", W'(in_ready), W'(1));
        check("rst_C", C, '0);
        rst = 1'b0;
        @(negedge clk);

        issue(32'h7FFF_FFFF, 32'h1, 32'h0, 1'b0, 4'b0010, 1);
        issue(32'h5, 32'hDEAD_BEEF, 32'h5, 1'b1, 4'b0110, 1);
        issue(32'hFFFF_FFFF, 32'h1, 32'h0, 1'b0, 4'b0111, 1);
        issue(32'hFFFF_FFFF, 32'h1, 32'h0, 1'b0, 4'b0011, 1);
        issue(32'h8000_0000, 32'd31, 32'h0, 1'b0, 4'b1011, 1);
        issue(32'h1234_5678, 32'h0, 32'h0, 1'b0, 4'b1000, 1);
        issue(32'hF0F0_0001, 32'd4, 32'h0, 1'b0, 4'b1010, 1);
        issue(32'h0000_FFFF, 32'h0001_0001, 32'h0, 1'b0, 4'b1100, 1);
        issue(32'hABCD_0123, 32'h1111_2222, 32'h0, 1'b0, 4'b0100, 1);
        drain();

        or_force = 1'b0;
        for (int i = 0; i < 150; i++) begin
            op = (i % 5 == 4) ? 4'($urandom) : ops[$urandom_range(0, 11)];
            a  = $urandom;
            b  = (i % 3 == 0) ? W'($urandom_range(0, 3)) : W'($urandom);
            s  = $urandom;
            issue(a, b, s, 1'($urandom), op, 1);
        end
        drain();

        or_force = 1'b1;
        or_val   = 1'b0;
        @(negedge clk);
        hold_c = model(32'h4000_0000, 32'h4000_0000, 4'b0010, hl);
        issue(32'h4000_0000, 32'h4000_0000, 32'h0, 1'b0, 4'b0010, 1);
        for (int i = 0; i < 10; i++) begin
            in_valid = 1'b1;
            rfrd1 = $urandom; rfrd2 = $urandom; alu_op = 4'b0001;
            @(negedge clk);
            check("hold_in_ready", W'(in_ready), W'(0));
            check("hold_out_valid", W'(out_valid), W'(1));
            check("hold_C", C, hold_c);
        end
        in_valid = 1'b0;
        or_val   = 1'b1;
        @(negedge clk);
        check("release_out_valid", W'(out_valid), W'(0));
        check("release_in_ready", W'(in_ready), W'(1));
        drain();

        issue(32'hFFFF_0000, 32'd20, 32'h0, 1'b0, 4'b1010, 0);
        repeat (2) @(negedge clk);
        rst      = 1'b1;
        in_valid = 1'b1;
        @(negedge clk);
        check("abort_out_valid", W'(out_valid), W'(0));
        check("abort_C", C, '0);
        check("abort_in_ready", W'(in_ready), W'(1));
        rst      = 1'b0;
        in_valid = 1'b0;
        repeat (40) @(negedge clk);
        check("abort_no_result", W'(out_valid), W'(0));

        issue(32'h0000_00FF, 32'h0000_0F0F, 32'h0, 1'b0, 4'b0000, 1);
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
